alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready
// result port. ADD/SUB/AND/OR/XOR and zero-length shifts finish in one cycle;
// shifts by n>0 iterate one bit per cycle through the SHIFT state.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request present on op/A/B
//   in_ready   request can be accepted (state == IDLE)
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 SRA
//   A, B       operands; for shifts B[SW-1:0] is the shift amount
//   out_valid  result/flags valid (state == DONE)
//   out_ready  consumer takes the result
//   result     registered result
//   cout       carry / borrow / last bit shifted out
//   zero       result is all zeros
//   ovf        signed overflow for ADD/SUB, else 0
//   busy       state != IDLE
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [2:0]       op_q, op_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [SW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] result_next;
  logic             cout_next, zero_next, ovf_next;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;
  logic [WIDTH-1:0] step_res;
  logic             step_out;

  // Single-cycle datapath on the live request inputs
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign shamt    = B[SW-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);

  always_comb begin
    alu_res  = A;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res  = sum_ext[WIDTH-1:0];
        alu_cout = sum_ext[WIDTH];
        alu_ovf  = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res  = diff_ext[WIDTH-1:0];
        alu_cout = diff_ext[WIDTH];
        alu_ovf  = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      // zero-length shifts pass A through with cout = 0
      default: alu_res = A;
    endcase
  end

  // One-bit shift step of the accumulator, plus the bit that falls off
  always_comb begin
    step_res = acc;
    step_out = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_res = {acc[MSB-1:0], 1'b0};
        step_out = acc[MSB];
      end
      OP_SHR: begin
        step_res = {1'b0, acc[MSB:1]};
        step_out = acc[0];
      end
      OP_SRA: begin
        step_res = {acc[MSB], acc[MSB:1]};
        step_out = acc[0];
      end
      default: begin
        step_res = acc;
        step_out = 1'b0;
      end
    endcase
  end

  // Next-state and next-register logic
  always_comb begin
    state_next  = state;
    op_next     = op_q;
    acc_next    = acc;
    cnt_next    = cnt;
    result_next = result;
    cout_next   = cout;
    zero_next   = zero;
    ovf_next    = ovf;

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_next = op;
          if (is_shift && (shamt != '0)) begin
            acc_next   = A;
            cnt_next   = shamt;
            state_next = SHIFT;
          end else begin
            result_next = alu_res;
            cout_next   = alu_cout;
            ovf_next    = alu_ovf;
            zero_next   = (alu_res == '0);
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_next = step_res;
        cnt_next = cnt - SW'(1);
        // last step publishes the result and the final shifted-out bit
        if (cnt == SW'(1)) begin
          result_next = step_res;
          cout_next   = step_out;
          ovf_next    = 1'b0;
          zero_next   = (step_res == '0);
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; status flags follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      result    <= result_next;
      cout      <= cout_next;
      zero      <= zero_next;
      ovf       <= ovf_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, backpressure,
// reset during SHIFT/DONE, and a random back-to-back stream against a model.
module tb_alu_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         busy;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of one request, written from the operation definitions
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [W:0]  w;
    int          n;
    n = int'(b[4:0]);
    e.c = 1'b0;
    e.v = 1'b0;
    e.lat = 1;
    case (o)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b};
        e.r = w[W-1:0];
        e.c = w[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b001: begin
        w = {1'b0, a} - {1'b0, b};
        e.r = w[W-1:0];
        e.c = w[W];
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b010: e.r = a & b;
      3'b011: e.r = a | b;
      3'b100: e.r = a ^ b;
      3'b101: begin
        e.r = a << n;
        if (n > 0) e.c = a[W-n];
      end
      3'b110: begin
        e.r = a >> n;
        if (n > 0) e.c = a[n-1];
      end
      default: begin
        e.r = $unsigned($signed(a) >>> n);
        if (n > 0) e.c = a[n-1];
      end
    endcase
    if (o >= 3'b101 && n > 0) e.lat = n + 1;
    e.z = (e.r == '0);
    return e;
  endfunction

  // Present one request, wait (bounded) for in_ready, hold it across the accepting edge
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < 200 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_ready: in_ready=%b required=1 after 200 cycles", in_ready);
    end
    op = o;
    A = a;
    B = b;
    in_valid = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and sample the result port; no checking here
  task automatic wait_out(output exp_t o, output bit to);
    to = 1'b0;
    for (int k = 0; k < 200 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!out_valid) to = 1'b1;
    o.r = result;
    o.c = cout;
    o.z = zero;
    o.v = ovf;
    o.lat = cyc - acc_cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 3'b000;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b r=%h c=%b z=%b v=%b required rdy=1 vld=0 busy=0 r=0 c=0 z=0 v=0",
               in_ready, out_valid, busy, result, cout, zero, ovf);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    vec_t tv[$];
    exp_t o, ex;
    bit   to;
    tv.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1}});
    tv.push_back('{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1}});
    tv.push_back('{3'b001, 32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1}});
    tv.push_back('{3'b001, 32'h0000_0003, 32'h0000_0005, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1}});
    tv.push_back('{3'b001, 32'h0000_0005, 32'h0000_0005, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1}});
    foreach (tv[i]) begin
      sb.push_back(tv[i].e);
      send(tv[i].op, tv[i].a, tv[i].b);
      wait_out(o, to);
      ex = sb.pop_front();
      n_cmp++;
      if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
        n_err++;
        $display("FAIL add_sub[%0d]: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
                 i, o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_logic();
    vec_t tv[$];
    exp_t o, ex;
    bit   to;
    tv.push_back('{3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1}});
    tv.push_back('{3'b011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1}});
    tv.push_back('{3'b100, 32'hAAAA_5555, 32'hAAAA_5555, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1}});
    foreach (tv[i]) begin
      sb.push_back(tv[i].e);
      send(tv[i].op, tv[i].a, tv[i].b);
      wait_out(o, to);
      ex = sb.pop_front();
      n_cmp++;
      if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
        n_err++;
        $display("FAIL logic[%0d]: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
                 i, o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift();
    vec_t tv[$];
    exp_t o, ex;
    bit   to;
    tv.push_back('{3'b111, 32'h8000_0010, 32'h0000_0004, '{32'hF800_0001, 1'b0, 1'b0, 1'b0, 5}});
    tv.push_back('{3'b101, 32'h8000_0001, 32'h0000_0000, '{32'h8000_0001, 1'b0, 1'b0, 1'b0, 1}});
    tv.push_back('{3'b110, 32'h0000_0003, 32'hFFFF_FFE1, '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 2}});
    tv.push_back('{3'b101, 32'h8000_0001, 32'h0000_0001, '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 2}});
    tv.push_back('{3'b110, 32'h0000_0001, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 2}});
    tv.push_back('{3'b101, 32'h0000_0003, 32'h0000_001F, '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 32}});
    tv.push_back('{3'b110, 32'hC000_0000, 32'h0000_001F, '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 32}});
    tv.push_back('{3'b111, 32'h8000_0000, 32'h0000_001F, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32}});
    foreach (tv[i]) begin
      sb.push_back(tv[i].e);
      send(tv[i].op, tv[i].a, tv[i].b);
      wait_out(o, to);
      ex = sb.pop_front();
      n_cmp++;
      if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
        n_err++;
        $display("FAIL shift[%0d]: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
                 i, o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t o, ex;
    bit   to;
    out_ready = 1'b0;
    sb.push_back(model(3'b010, 32'h1234_5678, 32'h0F0F_0F0F));
    send(3'b010, 32'h1234_5678, 32'h0F0F_0F0F);
    wait_out(o, to);
    ex = sb.pop_front();
    n_cmp++;
    if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != 1) begin
      n_err++;
      $display("FAIL bp_first: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=1",
               o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v);
    end
    // second request is offered while the result is stalled
    op = 3'b000;
    A = 32'd10;
    B = 32'd20;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || result !== ex.r ||
          cout !== ex.c || zero !== ex.z || ovf !== ex.v) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b busy=%b r=%h c=%b z=%b v=%b, required vld=1 rdy=0 busy=1 r=%h c=%b z=%b v=%b",
                 k, out_valid, in_ready, busy, result, cout, zero, ovf, ex.r, ex.c, ex.z, ex.v);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: rdy=%b vld=%b busy=%b, required rdy=1 vld=0 busy=0", in_ready, out_valid, busy);
    end
    sb.push_back('{32'd30, 1'b0, 1'b0, 1'b0, 1});
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(o, to);
    ex = sb.pop_front();
    n_cmp++;
    if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
      n_err++;
      $display("FAIL bp_second: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
               o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    exp_t o, ex;
    bit   to;
    int   seen;
    // SHL by 20: send returns in the 1st SHIFT cycle, two more edges reach the 3rd
    send(3'b101, 32'h1234_5678, 32'd20);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rst_shift: rdy=%b vld=%b busy=%b r=%h c=%b z=%b v=%b required rdy=1 vld=0 busy=0 r=0 c=0 z=0 v=0",
               in_ready, out_valid, busy, result, cout, zero, ovf);
    end
    reset = 1'b0;
    // reset while stalled in DONE
    out_ready = 1'b0;
    send(3'b100, 32'hFFFF_0000, 32'h00FF_FF00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 0 || result !== '0) begin
      n_err++;
      $display("FAIL rst_discard: out_valid cycles=%0d r=%h, required 0 cycles r=0", seen, result);
    end
    sb.push_back('{32'd4, 1'b0, 1'b0, 1'b0, 1});
    send(3'b000, 32'd2, 32'd2);
    wait_out(o, to);
    ex = sb.pop_front();
    n_cmp++;
    if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
      n_err++;
      $display("FAIL rst_add: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
               o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t       o, ex;
    bit         to;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb[4:0] = 5'($urandom_range(0, 3));
      sb.push_back(model(ro, ra, rb));
      send(ro, ra, rb);
      wait_out(o, to);
      ex = sb.pop_front();
      n_cmp++;
      if (to || o.r !== ex.r || o.c !== ex.c || o.z !== ex.z || o.v !== ex.v || o.lat != ex.lat) begin
        n_err++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got r=%h c=%b z=%b v=%b lat=%0d to=%b, required r=%h c=%b z=%b v=%b lat=%0d",
                 i, ro, ra, rb, o.r, o.c, o.z, o.v, o.lat, to, ex.r, ex.c, ex.z, ex.v, ex.lat);
      end
      @(posedge clk); #1;
      // one idle cycle after the handshake, then the next request goes straight in
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle[%0d]: rdy=%b vld=%b, required rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = '0;
    A = '0;
    B = '0;
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
